// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: one countdown timer per register,
// stalls ID consumers until a pending load's data can be forwarded.
module hazard_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 16,
  localparam int REG_W   = $clog2(NUM_REGS),
  localparam int CNT_W   = $clog2(LOAD_LAT + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     id_valid,
  input  logic                     id_mem_read,
  input  logic [REG_W-1:0]         id_dest,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic                     flush,
  input  logic                     mem_stall,
  input  logic                     perf_clr,
  output logic                     forward_load,
  output logic                     controlmux_sel,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic [PERF_W-1:0]        stall_cycles
);

  logic [CNT_W-1:0]  cnt_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d [NUM_REGS];
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] stall_d;
  logic              hazard;
  logic              advance;
  logic              alloc;

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_src_used[k] &&
          (cnt_q[id_src[k*REG_W +: REG_W]] != '0))
        hazard = 1'b1;
    end
    hazard = hazard & id_valid & ~flush;
  end

  assign advance = id_valid & ~flush & ~hazard & ~mem_stall;
  assign alloc   = advance & id_mem_read;

  // Allocation wins over decrement on the same register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!mem_stall) begin
        if (alloc && (id_dest == REG_W'(r)))
          cnt_d[r] = CNT_W'(LOAD_LAT);
        else if (cnt_q[r] != '0)
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (perf_clr)
      stall_d = '0;
    else if (hazard && !mem_stall && !(&stall_q))
      stall_d = stall_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= '0;
      stall_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= cnt_d[r];
      stall_q <= stall_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      busy_vec[r] = (cnt_q[r] != '0);
  end

  assign forward_load   = ~hazard;
  assign controlmux_sel = hazard;
  assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: instance a uses LOAD_LAT=1, instance b uses
// LOAD_LAT=3 with a 4-bit bubble counter.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset_n;
  logic       id_valid;
  logic       id_mem_read;
  logic [2:0] id_dest;
  logic [5:0] id_src;
  logic [1:0] id_src_used;
  logic       flush;
  logic       mem_stall;
  logic       perf_clr;

  logic        fwd_a, cms_a;
  logic [7:0]  busy_a;
  logic [15:0] stall_a;
  logic        fwd_b, cms_b;
  logic [7:0]  busy_b;
  logic [3:0]  stall_b;

  int n_chk;
  int n_fail;

  hazard_scoreboard #(
    .NUM_REGS(8), .NUM_SRC(2), .LOAD_LAT(1), .PERF_W(16)
  ) u_a (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .id_src(id_src),
    .id_src_used(id_src_used), .flush(flush),
    .mem_stall(mem_stall), .perf_clr(perf_clr),
    .forward_load(fwd_a), .controlmux_sel(cms_a),
    .busy_vec(busy_a), .stall_cycles(stall_a)
  );

  hazard_scoreboard #(
    .NUM_REGS(8), .NUM_SRC(2), .LOAD_LAT(3), .PERF_W(4)
  ) u_b (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .id_src(id_src),
    .id_src_used(id_src_used), .flush(flush),
    .mem_stall(mem_stall), .perf_clr(perf_clr),
    .forward_load(fwd_b), .controlmux_sel(cms_b),
    .busy_vec(busy_b), .stall_cycles(stall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_mem_read = 1'b0;
    id_dest     = 3'd0;
    id_src      = 6'd0;
    id_src_used = 2'b00;
    flush       = 1'b0;
    mem_stall   = 1'b0;
    perf_clr    = 1'b0;
    #1;
  endtask

  // ID holds an instruction; s1 in the upper source slot
  task automatic instr(input logic mr, input logic [2:0] d,
                       input logic [2:0] s0, input logic [2:0] s1,
                       input logic [1:0] used);
    id_valid    = 1'b1;
    id_mem_read = mr;
    id_dest     = d;
    id_src      = {s1, s0};
    id_src_used = used;
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    idle();
    tick();
    reset_n = 1'b1;
    #1;

    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_fwd", 32'(fwd_a), 32'h1);
    check("rst_cms", 32'(cms_a), 32'h0);
    check("rst_stall", 32'(stall_a), 32'h0);

    // Test 1: async reset mid-countdown
    instr(1'b1, 3'd3, 3'd0, 3'd0, 2'b00);
    tick();
    check("t1_busy3", 32'(busy_a), 32'h08);
    instr(1'b0, 3'd1, 3'd3, 3'd0, 2'b01);
    check("t1_haz", 32'(cms_a), 32'h1);
    reset_n = 1'b0;
    #1;
    check("t1_rbusy", 32'(busy_a), 32'h0);
    check("t1_rfwd", 32'(fwd_a), 32'h1);
    check("t1_rcms", 32'(cms_a), 32'h0);
    idle();
    tick();
    reset_n = 1'b1;
    #1;

    // Test 2: LOAD_LAT=1 single bubble
    instr(1'b1, 3'd2, 3'd0, 3'd0, 2'b00);
    check("t2_ldfwd", 32'(fwd_a), 32'h1);
    tick();
    instr(1'b0, 3'd1, 3'd2, 3'd0, 2'b01);
    check("t2_cms", 32'(cms_a), 32'h1);
    check("t2_fwd", 32'(fwd_a), 32'h0);
    tick();
    check("t2_cms2", 32'(cms_a), 32'h0);
    check("t2_fwd2", 32'(fwd_a), 32'h1);
    check("t2_stall", 32'(stall_a), 32'h1);
    tick();
    check("t2_stall2", 32'(stall_a), 32'h1);

    // Test 3: LOAD_LAT=3 with a 2-cycle freeze
    do_reset();
    instr(1'b1, 3'd2, 3'd0, 3'd0, 2'b00);
    tick();
    check("t3_busy", 32'(busy_b), 32'h04);
    instr(1'b0, 3'd1, 3'd0, 3'd2, 2'b10);
    mem_stall = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("t3_frz_cms", 32'(cms_b), 32'h1);
      tick();
    end
    check("t3_frz_stall", 32'(stall_b), 32'h0);
    check("t3_frz_busy", 32'(busy_b), 32'h04);
    mem_stall = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t3_cms", 32'(cms_b), 32'h1);
      tick();
    end
    check("t3_go", 32'(cms_b), 32'h0);
    check("t3_stall", 32'(stall_b), 32'h3);

    // Test 4: unused source and flush
    do_reset();
    instr(1'b1, 3'd2, 3'd0, 3'd0, 2'b00);
    tick();
    instr(1'b0, 3'd1, 3'd2, 3'd2, 2'b00);
    check("t4_unused", 32'(cms_b), 32'h0);
    tick();
    instr(1'b1, 3'd6, 3'd2, 3'd0, 2'b01);
    flush = 1'b1;
    #1;
    check("t4_flush", 32'(cms_b), 32'h0);
    tick();
    check("t4_noalloc", 32'(busy_b), 32'h04);
    idle();
    tick();
    check("t4_drain", 32'(busy_b), 32'h0);

    // Test 5: reload of R5, then load-to-self on R4
    instr(1'b1, 3'd5, 3'd0, 3'd0, 2'b00);
    tick();
    check("t5_busy5", 32'(busy_b), 32'h20);
    idle();
    tick();
    instr(1'b1, 3'd5, 3'd1, 3'd0, 2'b01);
    check("t5_ld2", 32'(cms_b), 32'h0);
    tick();
    idle();
    tick();
    tick();
    check("t5_reload", 32'(busy_b), 32'h20);
    tick();
    check("t5_done", 32'(busy_b), 32'h0);
    instr(1'b1, 3'd4, 3'd0, 3'd0, 2'b00);
    tick();
    instr(1'b1, 3'd4, 3'd4, 3'd0, 2'b01);
    for (int i = 0; i < 3; i++) begin
      check("t5_self", 32'(cms_b), 32'h1);
      tick();
    end
    check("t5_selfgo", 32'(cms_b), 32'h0);
    tick();
    check("t5_selfbusy", 32'(busy_b), 32'h10);

    // Test 6: saturation and clear priority
    do_reset();
    instr(1'b1, 3'd1, 3'd0, 3'd0, 2'b00);
    tick();
    instr(1'b1, 3'd1, 3'd1, 3'd0, 2'b01);
    for (int i = 0; i < 30; i++)
      tick();
    check("t6_sat", 32'(stall_b), 32'hf);
    check("t6_haz", 32'(cms_b), 32'h1);
    perf_clr = 1'b1;
    #1;
    tick();
    check("t6_clr", 32'(stall_b), 32'h0);

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
